mskaes_128bits_round_iter: RTL and testbench

//  Iterative controller and state/key register bank for the masked AES-128 encryption core.

---
 rtl/mskaes_128bits_round_iter.sv | 109 ++++++++++
 tb/tb_mskaes_128bits_round_iter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_128bits_round_iter.sv
// Iterative controller and share-wise state/key register bank for the masked AES-128 core.
// Drives the external masked round, captures its outputs after LATENCY cycles, and applies the final AddRoundKey.
`timescale 1ns/1ps
module mskaes_128bits_round_iter #(
  parameter int d       = 2,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [128*d-1:0]   sh_plaintext,
  input  logic [128*d-1:0]   sh_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [128*d-1:0]   sh_ciphertext,
  output logic               rnd_en,
  output logic [128*d-1:0]   rd_state,
  output logic [128*d-1:0]   rd_key,
  output logic [8*d-1:0]     rd_rcon,
  input  logic [128*d-1:0]   rd_state_out,
  input  logic [128*d-1:0]   rd_state_sr_out,
  input  logic [128*d-1:0]   rd_key_out
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_fsm;
  logic [128*d-1:0]   r_state;
  logic [128*d-1:0]   r_key;
  logic [128*d-1:0]   r_ct;
  logic [3:0]         r_round;
  logic [LAT_W-1:0]   r_lat;
  logic [7:0]         r_rcon;
  logic [7:0]         w_rcon_next;

  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_ct    <= '0;
      r_round <= '0;
      r_lat   <= '0;
      r_rcon  <= 8'h00;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= sh_plaintext;
            r_key   <= sh_key;
            r_round <= 4'd1;
            r_lat   <= '0;
            r_rcon  <= 8'h01;
            r_fsm   <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_lat == LAT_LAST) begin
            r_lat <= '0;
            r_key <= rd_key_out;
            // The last round takes the pre-MixColumns tap; the round keeps computing MC regardless.
            if (r_round < 4'd10) begin
              r_state <= rd_state_out;
              r_round <= r_round + 4'd1;
              r_rcon  <= w_rcon_next;
            end else begin
              r_state <= rd_state_sr_out;
              r_fsm   <= S_FINAL;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_FINAL: begin
          // Share-wise XOR keeps the ciphertext masked; shares are never recombined here.
          r_ct  <= r_state ^ r_key;
          r_fsm <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_fsm <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_fsm == S_IDLE);
  assign out_valid     = (r_fsm == S_DONE);
  assign rnd_en        = (r_fsm == S_RUN);
  assign rd_state      = r_state;
  assign rd_key        = r_key;
  assign sh_ciphertext = r_ct;

  // RCON is public: only share 0 carries it, the remaining shares are zero.
  always_comb begin
    rd_rcon      = '0;
    rd_rcon[7:0] = r_rcon;
  end

endmodule

// File: tb/tb_mskaes_128bits_round_iter.sv
// Bench for mskaes_128bits_round_iter: two instances (d=2/LATENCY=4 and d=3/LATENCY=1), each
// wrapped by a behavioural masked round (unmask, AES round, remask with fresh randomness).
`timescale 1ns/1ps
module tb_mskaes_128bits_round_iter;

  localparam int DA = 2;
  localparam int LA = 4;
  localparam int DB = 3;
  localparam int LB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_rnd_en;
  logic [128*DA-1:0]   a_pt, a_key, a_ct, a_rd_state, a_rd_key, a_st_out, a_sr_out, a_key_out;
  logic [8*DA-1:0]     a_rcon;
  logic                b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_rnd_en;
  logic [128*DB-1:0]   b_pt, b_key, b_ct, b_rd_state, b_rd_key, b_st_out, b_sr_out, b_key_out;
  logic [8*DB-1:0]     b_rcon;

  mskaes_128bits_round_iter #(.d(DA), .LATENCY(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sh_plaintext(a_pt), .sh_key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sh_ciphertext(a_ct), .rnd_en(a_rnd_en), .rd_state(a_rd_state), .rd_key(a_rd_key),
    .rd_rcon(a_rcon), .rd_state_out(a_st_out), .rd_state_sr_out(a_sr_out), .rd_key_out(a_key_out));

  mskaes_128bits_round_iter #(.d(DB), .LATENCY(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sh_plaintext(b_pt), .sh_key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sh_ciphertext(b_ct), .rnd_en(b_rnd_en), .rd_state(b_rd_state), .rd_key(b_rd_key),
    .rd_rcon(b_rcon), .rd_state_out(b_st_out), .rd_state_sr_out(b_sr_out), .rd_key_out(b_key_out));

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // GF(2^8) inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sbsr(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    logic [7:0] rc;
    s = pt; k = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      s = sbsr(s ^ k);
      if (r < 10) s = mixc(s);
      k = keyexp(k, rc);
      rc = xt(rc);
    end
    return s ^ k;
  endfunction

  function automatic logic [127:0] unmask(input logic [383:0] bus, input int nd);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < nd; i++) v = v ^ bus[128*i +: 128];
    return v;
  endfunction

  function automatic logic [7:0] unmask8(input logic [23:0] bus, input int nd);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < nd; i++) v = v ^ bus[8*i +: 8];
    return v;
  endfunction

  function automatic logic [383:0] remask(input logic [127:0] v, input logic [383:0] m, input int nd);
    logic [383:0] o;
    logic [127:0] acc;
    o = '0; acc = v;
    for (int i = 1; i < nd; i++) begin
      o[128*i +: 128] = m[128*i +: 128];
      acc = acc ^ m[128*i +: 128];
    end
    o[127:0] = acc;
    return o;
  endfunction

  // ---------------- behavioural masked rounds ----------------
  logic [383:0] m_a, m_b;
  always @(posedge clk)
    for (int i = 0; i < 12; i++) begin
      m_a[32*i +: 32] <= $urandom;
      m_b[32*i +: 32] <= $urandom;
    end

  logic [127:0] a_us, a_uk, a_t, b_us, b_uk, b_t;
  logic [7:0]   a_ur, b_ur;
  logic [383:0] a_cs, a_csr, a_ck, b_cs, b_csr, b_ck;
  always_comb begin
    a_us  = unmask(384'(a_rd_state), DA);
    a_uk  = unmask(384'(a_rd_key), DA);
    a_ur  = unmask8(24'(a_rcon), DA);
    a_t   = sbsr(a_us ^ a_uk);
    a_csr = remask(a_t, m_a, DA);
    a_cs  = remask(mixc(a_t), m_a, DA);
    a_ck  = remask(keyexp(a_uk, a_ur), {m_a[191:0], m_a[383:192]}, DA);
    b_us  = unmask(b_rd_state, DB);
    b_uk  = unmask(b_rd_key, DB);
    b_ur  = unmask8(b_rcon, DB);
    b_t   = sbsr(b_us ^ b_uk);
    b_csr = remask(b_t, m_b, DB);
    b_cs  = remask(mixc(b_t), m_b, DB);
    b_ck  = remask(keyexp(b_uk, b_ur), {m_b[191:0], m_b[383:192]}, DB);
  end

  // Round A: LATENCY-1 register stages so outputs are valid exactly LATENCY edges after inputs
  logic [383:0] a_ps [LA-1];
  logic [383:0] a_psr[LA-1];
  logic [383:0] a_pk [LA-1];
  always @(posedge clk) begin
    a_ps[0] <= a_cs; a_psr[0] <= a_csr; a_pk[0] <= a_ck;
    for (int i = 1; i < LA-1; i++) begin
      a_ps[i] <= a_ps[i-1]; a_psr[i] <= a_psr[i-1]; a_pk[i] <= a_pk[i-1];
    end
  end
  assign a_st_out  = a_ps[LA-2][128*DA-1:0];
  assign a_sr_out  = a_psr[LA-2][128*DA-1:0];
  assign a_key_out = a_pk[LA-2][128*DA-1:0];
  assign b_st_out  = b_cs;
  assign b_sr_out  = b_csr;
  assign b_key_out = b_ck;

  // ---------------- scoreboard and helpers ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] q_a[$];
  logic [127:0] q_b[$];
  logic [7:0]   rcon_seen[10];
  logic [7:0]   rcon_exp[10];
  bit           rcon_hi_bad = 1'b0;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic start_a(input logic [127:0] pt, input logic [127:0] key);
    logic [383:0] mm, t;
    for (int i = 0; i < 12; i++) mm[32*i +: 32] = $urandom;
    t = remask(pt, mm, DA); a_pt = t[128*DA-1:0];
    for (int i = 0; i < 12; i++) mm[32*i +: 32] = $urandom;
    t = remask(key, mm, DA); a_key = t[128*DA-1:0];
    a_in_valid = 1'b1;
    q_a.push_back(aes_ref(pt, key));
  endtask

  task automatic wait_a(output int cyc, output int rnd);
    cyc = 0; rnd = 0;
    for (int k = 0; k < 10; k++) rcon_seen[k] = 8'hxx;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) a_in_valid = 1'b0;
      if (a_rnd_en) begin
        rnd++;
        if ((cyc - 1) % LA == 0 && (cyc - 1) / LA < 10) rcon_seen[(cyc - 1) / LA] = a_rcon[7:0];
      end
      if (a_rcon[8*DA-1:8] != '0) rcon_hi_bad = 1'b1;
      if (a_out_valid || cyc >= 400) break;
    end
  endtask

  task automatic consume_a();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_chk++;
    if ({a_in_ready, a_out_valid, a_rnd_en} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctl_a: got %b want 100", {a_in_ready, a_out_valid, a_rnd_en});
    end
    n_chk++;
    if ({a_ct, a_rd_state, a_rd_key, a_rcon} !== '0) begin
      n_fail++; $display("FAIL reset_data_a: ct %h state %h key %h rcon %h want all zero", a_ct, a_rd_state, a_rd_key, a_rcon);
    end
    n_chk++;
    if ({b_in_ready, b_out_valid, b_rnd_en} !== 3'b100 || {b_ct, b_rd_state, b_rd_key, b_rcon} !== '0) begin
      n_fail++; $display("FAIL reset_b: ctl %b ct %h want 100 and zero", {b_in_ready, b_out_valid, b_rnd_en}, b_ct);
    end
  endtask

  task automatic test_fips();
    int cyc, rnd;
    logic [127:0] got, exp;
    start_a(FIPS_PT, FIPS_KEY);
    wait_a(cyc, rnd);
    got = unmask(384'(a_ct), DA);
    exp = q_a.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL fips_sb: got %h want %h", got, exp); end
    n_chk++;
    if (got !== FIPS_CT) begin n_fail++; $display("FAIL fips_ct: got %h want %h", got, FIPS_CT); end
    n_chk++;
    if (cyc != 10*LA+2) begin n_fail++; $display("FAIL fips_latency: got %0d want %0d", cyc, 10*LA+2); end
    n_chk++;
    if (rnd != 10*LA) begin n_fail++; $display("FAIL fips_rnd_en: got %0d want %0d", rnd, 10*LA); end
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (rcon_seen[k] !== rcon_exp[k]) begin
        n_fail++; $display("FAIL rcon_round%0d: got %h want %h", k + 1, rcon_seen[k], rcon_exp[k]);
      end
    end
    n_chk++;
    if (rcon_hi_bad) begin n_fail++; $display("FAIL rcon_upper_shares: got nonzero want 0"); end
    consume_a();
    n_chk++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL fips_release: got %b want 10", {a_in_ready, a_out_valid});
    end
  endtask

  task automatic test_lat1();
    int cyc, rnd;
    logic [383:0] mm, t;
    logic [127:0] got, exp;
    for (int i = 0; i < 12; i++) mm[32*i +: 32] = $urandom;
    t = remask(FIPS_PT, mm, DB); b_pt = t;
    for (int i = 0; i < 12; i++) mm[32*i +: 32] = $urandom;
    t = remask(FIPS_KEY, mm, DB); b_key = t;
    b_in_valid = 1'b1;
    q_b.push_back(aes_ref(FIPS_PT, FIPS_KEY));
    cyc = 0; rnd = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      b_in_valid = 1'b0;
      if (b_rnd_en) rnd++;
      if (b_out_valid || cyc >= 100) break;
    end
    got = unmask(b_ct, DB);
    exp = q_b.pop_front();
    n_chk++;
    if (got !== exp || got !== FIPS_CT) begin n_fail++; $display("FAIL lat1_ct: got %h want %h", got, FIPS_CT); end
    n_chk++;
    if (cyc != 10*LB+2) begin n_fail++; $display("FAIL lat1_latency: got %0d want %0d", cyc, 10*LB+2); end
    n_chk++;
    if (rnd != 10) begin n_fail++; $display("FAIL lat1_rnd_en: got %0d want 10", rnd); end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_chk++;
    if ({b_in_ready, b_out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL lat1_release: got %b want 10", {b_in_ready, b_out_valid});
    end
  endtask

  task automatic test_hold_out();
    int cyc, rnd;
    logic [128*DA-1:0] ct0;
    logic [127:0] got, exp, pt2;
    start_a(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_a(cyc, rnd);
    ct0 = a_ct;
    exp = q_a.pop_front();
    got = unmask(384'(ct0), DA);
    n_chk++;
    if (got !== exp || got !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      n_fail++; $display("FAIL hold_ct: got %h want 3925841d02dc09fbdc118597196a0b32", got);
    end
    a_in_valid = 1'b1;
    a_pt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (a_ct !== ct0 || {a_in_ready, a_out_valid} !== 2'b01) begin
        n_fail++; $display("FAIL hold_stable_%0d: ct %h ctl %b want ct %h ctl 01", i, a_ct, {a_in_ready, a_out_valid}, ct0);
      end
    end
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    a_out_ready = 1'b1;
    start_a(pt2, FIPS_KEY);
    @(negedge clk);
    a_out_ready = 1'b0;
    n_chk++;
    if ({a_in_ready, a_out_valid, a_rnd_en} !== 3'b100) begin
      n_fail++; $display("FAIL hold_back_idle: got %b want 100", {a_in_ready, a_out_valid, a_rnd_en});
    end
    wait_a(cyc, rnd);
    got = unmask(384'(a_ct), DA);
    exp = q_a.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL hold_second_ct: got %h want %h", got, exp); end
    n_chk++;
    if (cyc != 10*LA+2) begin n_fail++; $display("FAIL hold_second_latency: got %0d want %0d", cyc, 10*LA+2); end
    consume_a();
  endtask

  task automatic test_reset_mid();
    int cyc, rnd;
    logic [127:0] got, exp, pt, key;
    start_a({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    repeat (18) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    void'(q_a.pop_back());
    n_chk++;
    if ({a_in_ready, a_out_valid, a_rnd_en} !== 3'b100) begin
      n_fail++; $display("FAIL midreset_ctl: got %b want 100", {a_in_ready, a_out_valid, a_rnd_en});
    end
    n_chk++;
    if ({a_ct, a_rd_state, a_rd_key, a_rcon} !== '0) begin
      n_fail++; $display("FAIL midreset_data: ct %h state %h key %h rcon %h want all zero", a_ct, a_rd_state, a_rd_key, a_rcon);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    start_a(pt, key);
    wait_a(cyc, rnd);
    got = unmask(384'(a_ct), DA);
    exp = q_a.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL midreset_after_ct: got %h want %h", got, exp); end
    n_chk++;
    if (cyc != 10*LA+2) begin n_fail++; $display("FAIL midreset_after_latency: got %0d want %0d", cyc, 10*LA+2); end
    consume_a();
  endtask

  task automatic test_back_to_back();
    int cyc, rnd;
    logic [128*DA-1:0] ct1, ct2;
    logic [127:0] pt, key, u1, u2, exp;
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    start_a(pt, key);
    wait_a(cyc, rnd);
    ct1 = a_ct;
    consume_a();
    start_a(pt, key);
    wait_a(cyc, rnd);
    ct2 = a_ct;
    consume_a();
    u1 = unmask(384'(ct1), DA);
    u2 = unmask(384'(ct2), DA);
    exp = q_a.pop_front();
    n_chk++;
    if (u1 !== exp) begin n_fail++; $display("FAIL b2b_first: got %h want %h", u1, exp); end
    exp = q_a.pop_front();
    n_chk++;
    if (u2 !== exp) begin n_fail++; $display("FAIL b2b_second: got %h want %h", u2, exp); end
    n_chk++;
    if (u1 !== u2) begin n_fail++; $display("FAIL b2b_equal_unmasked: got %h want %h", u2, u1); end
    n_chk++;
    if (ct1 === ct2) begin n_fail++; $display("FAIL b2b_shares_differ: got identical %h want differing shares", ct2); end
  endtask

  initial begin
    rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_pt = '0; a_key = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_pt = '0; b_key = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fips();
    test_lat1();
    test_hold_out();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d/%0d left want 0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
